// File: rtl/pcie_perst_gen.sv
// pcie_perst_gen: initiator-side PERST# sequencer with power-good qualification,
// link-up timeout monitoring, bounded retry re-pulsing and software reset requests.
//
// Ports:
//   clk        - clock; every other input is synchronous to it
//   rst        - asynchronous active-low reset
//   pwr_good   - slot power stable
//   link_up    - link trained indication from the LTSSM / data-link layer
//   reset_req  - single-cycle software request for a fresh PERST# pulse
//   perst_n    - registered PERST# to the device (active-low)
//   link_ok    - high while the link is up
//   link_fail  - high while in the sticky failure state
//   retry_cnt  - retries consumed in the current attempt (saturating)
//   state_o    - encoded state for CSR / debug
module pcie_perst_gen #(
    parameter int PWR_STABLE_CYCLES   = 10000000,
    parameter int PERST_MIN_CYCLES    = 10000,
    parameter int LINK_TIMEOUT_CYCLES = 100000000,
    parameter int MAX_RETRIES         = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwr_good,
    input  logic          link_up,
    input  logic          reset_req,
    output logic          perst_n,
    output logic          link_ok,
    output logic          link_fail,
    output logic [RW-1:0] retry_cnt,
    output logic [2:0]    state_o
);

    localparam int MAX_A   = (PWR_STABLE_CYCLES > PERST_MIN_CYCLES) ?
                             PWR_STABLE_CYCLES : PERST_MIN_CYCLES;
    localparam int MAX_CNT = (MAX_A > LINK_TIMEOUT_CYCLES) ?
                             MAX_A : LINK_TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    // Terminal counts: the transition happens on the edge that completes the
    // N-th cycle, so the counter is compared against N-1.
    localparam logic [CW-1:0] PWR_LAST  = (PWR_STABLE_CYCLES > 1) ?
                                          CW'(PWR_STABLE_CYCLES - 1) : '0;
    localparam logic [CW-1:0] HOLD_LAST = (PERST_MIN_CYCLES > 1) ?
                                          CW'(PERST_MIN_CYCLES - 1) : '0;
    localparam logic [CW-1:0] TO_LAST   = (LINK_TIMEOUT_CYCLES > 1) ?
                                          CW'(LINK_TIMEOUT_CYCLES - 1) : '0;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_UP       = 3'd3,
        ST_HOLD     = 3'd4,
        ST_FAIL     = 3'd5
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_retry;
    logic          r_perst_n;
    logic          r_link_ok;
    logic          r_link_fail;

    logic w_req_ok;
    logic w_pwr_done;
    logic w_hold_done;
    logic w_timeout;
    logic w_retry_left;

    // Software requests only matter once the slot has been powered and released.
    assign w_req_ok     = reset_req &&
                          (r_state == ST_RELEASE || r_state == ST_UP ||
                           r_state == ST_HOLD    || r_state == ST_FAIL);
    assign w_pwr_done   = (r_cnt >= PWR_LAST);
    assign w_hold_done  = (r_cnt >= HOLD_LAST);
    assign w_timeout    = (r_cnt >= TO_LAST);
    assign w_retry_left = (r_retry < RETRY_MAX);

    // perst_n defaults low every cycle and is only raised on paths that land in
    // RELEASE or UP, so it can never be high anywhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_perst_n   <= 1'b0;
            r_link_ok   <= 1'b0;
            r_link_fail <= 1'b0;
        end else begin
            r_perst_n   <= 1'b0;
            r_link_ok   <= 1'b0;
            r_link_fail <= 1'b0;
            if (!pwr_good) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_retry <= '0;
            end else if (w_req_ok) begin
                // Restarts the full hold width, even when already holding.
                r_state <= ST_HOLD;
                r_cnt   <= '0;
                r_retry <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_retry <= '0;
                        // This sample is the first consecutive high one.
                        if (PWR_STABLE_CYCLES <= 1) begin
                            r_state   <= ST_RELEASE;
                            r_cnt     <= '0;
                            r_perst_n <= 1'b1;
                        end else begin
                            r_state <= ST_PWR_WAIT;
                            r_cnt   <= CW'(1);
                        end
                    end
                    ST_PWR_WAIT: begin
                        if (w_pwr_done) begin
                            r_state   <= ST_RELEASE;
                            r_cnt     <= '0;
                            r_perst_n <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        // link_up beats a coincident timeout.
                        if (link_up) begin
                            r_state   <= ST_UP;
                            r_cnt     <= '0;
                            r_perst_n <= 1'b1;
                            r_link_ok <= 1'b1;
                        end else if (w_timeout) begin
                            r_cnt <= '0;
                            if (w_retry_left) begin
                                r_state <= ST_HOLD;
                                r_retry <= r_retry + 1'b1;
                            end else begin
                                r_state     <= ST_FAIL;
                                r_link_fail <= 1'b1;
                            end
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_perst_n <= 1'b1;
                        end
                    end
                    ST_UP: begin
                        if (!link_up) begin
                            // Surprise link-down: fresh attempt.
                            r_state <= ST_HOLD;
                            r_cnt   <= '0;
                            r_retry <= '0;
                        end else begin
                            r_perst_n <= 1'b1;
                            r_link_ok <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (w_hold_done) begin
                            r_state   <= ST_RELEASE;
                            r_cnt     <= '0;
                            r_perst_n <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_FAIL: begin
                        r_link_fail <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_retry <= '0;
                    end
                endcase
            end
        end
    end

    assign perst_n   = r_perst_n;
    assign link_ok   = r_link_ok;
    assign link_fail = r_link_fail;
    assign retry_cnt = r_retry;
    assign state_o   = r_state;

    a_perst_safe: assert property (@(posedge clk) disable iff (!rst)
        r_perst_n |-> (r_state == ST_RELEASE || r_state == ST_UP));

    a_retry_sat: assert property (@(posedge clk) disable iff (!rst)
        r_retry <= RETRY_MAX);

endmodule

// File: tb/tb_pcie_perst_gen.sv
// tb_pcie_perst_gen: vector table, directed corner sequences and randomized
// stimulus against a cycle-level reference model of pcie_perst_gen.
module tb_pcie_perst_gen;

    localparam int PWR  = 10;
    localparam int MIN  = 5;
    localparam int TO   = 20;
    localparam int MAXR = 2;

    localparam int S_IDLE = 0;
    localparam int S_PW   = 1;
    localparam int S_REL  = 2;
    localparam int S_UP   = 3;
    localparam int S_HOLD = 4;
    localparam int S_FAIL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pwr_good = 1'b0;
    logic       link_up = 1'b0;
    logic       reset_req = 1'b0;
    logic       perst_n;
    logic       link_ok;
    logic       link_fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcie_perst_gen #(
        .PWR_STABLE_CYCLES  (PWR),
        .PERST_MIN_CYCLES   (MIN),
        .LINK_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwr_good (pwr_good),
        .link_up  (link_up),
        .reset_req(reset_req),
        .perst_n  (perst_n),
        .link_ok  (link_ok),
        .link_fail(link_fail),
        .retry_cnt(retry_cnt),
        .state_o  (state_o)
    );

    // Reference model: phase, consecutive power-good run, cycles elapsed in
    // the current timed phase, retries used.
    int m_ph, m_run, m_el, m_ret;

    function automatic void m_reset();
        m_ph  = S_IDLE;
        m_run = 0;
        m_el  = 0;
        m_ret = 0;
    endfunction

    function automatic void m_step(logic pg, logic lu, logic rq);
        if (!pg) begin
            m_reset();
        end else if (rq && m_ph >= S_REL) begin
            m_ph  = S_HOLD;
            m_el  = 0;
            m_ret = 0;
        end else begin
            case (m_ph)
                S_IDLE: begin
                    m_run = 1;
                    m_el  = 0;
                    m_ph  = (m_run >= PWR) ? S_REL : S_PW;
                end
                S_PW: begin
                    m_run++;
                    if (m_run >= PWR) begin
                        m_ph = S_REL;
                        m_el = 0;
                    end
                end
                S_REL: begin
                    if (lu) begin
                        m_ph = S_UP;
                    end else begin
                        m_el++;
                        if (m_el >= TO) begin
                            m_el = 0;
                            if (m_ret < MAXR) begin
                                m_ret++;
                                m_ph = S_HOLD;
                            end else begin
                                m_ph = S_FAIL;
                            end
                        end
                    end
                end
                S_UP: begin
                    if (!lu) begin
                        m_ph  = S_HOLD;
                        m_el  = 0;
                        m_ret = 0;
                    end
                end
                S_HOLD: begin
                    m_el++;
                    if (m_el >= MIN) begin
                        m_ph = S_REL;
                        m_el = 0;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step(pwr_good, link_up, reset_req);
        #1;
    endtask

    task automatic chk(string nm, logic ep, logic eo, logic ef,
                       logic [1:0] er, logic [2:0] es);
        total++;
        if ({perst_n, link_ok, link_fail, retry_cnt, state_o} !==
            {ep, eo, ef, er, es}) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s t=%0t got perst=%b ok=%b fail=%b retry=%0d state=%0d want perst=%b ok=%b fail=%b retry=%0d state=%0d",
                         nm, $time, perst_n, link_ok, link_fail, retry_cnt, state_o,
                         ep, eo, ef, er, es);
        end
    endtask

    task automatic chk_model(string nm);
        logic [1:0] r;
        logic [2:0] s;
        r = m_ret[1:0];
        s = m_ph[2:0];
        chk(nm, (m_ph == S_REL) || (m_ph == S_UP), m_ph == S_UP,
            m_ph == S_FAIL, r, s);
    endtask

    task automatic chk_val(string nm, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic do_reset(logic pg_during);
        rst       = 1'b0;
        pwr_good  = pg_during;
        link_up   = 1'b0;
        reset_req = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_hold", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        m_reset();
        rst = 1'b1;
    endtask

    // Ticks until perst_n rises (bounded); returns edges taken.
    task automatic wait_release(string nm, output int n);
        n = 0;
        do begin
            tick();
            n++;
            chk_model(nm);
        end while (!perst_n && n < 40);
    endtask

    typedef struct {
        logic       pg, lu, rq;
        logic       ep, eo, ef;
        logic [1:0] er;
        logic [2:0] es;
    } vec_t;

    vec_t tv[15];

    initial begin
        int n;
        logic exp_p;

        // Power-up vectors, one per clock edge after reset release.
        for (int i = 0; i < 9; i++)
            tv[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2};
        tv[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2};
        tv[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2};
        tv[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd3};
        tv[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd3};
        tv[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4};

        #2;
        chk("por_state", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) begin
            pwr_good  = tv[i].pg;
            link_up   = tv[i].lu;
            reset_req = tv[i].rq;
            tick();
            chk($sformatf("vec%0d", i), tv[i].ep, tv[i].eo, tv[i].ef,
                tv[i].er, tv[i].es);
        end
        reset_req = 1'b0;

        // Power glitch during qualification.
        do_reset(1'b0);
        pwr_good = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_model("glitch_wait");
        end
        pwr_good = 1'b0;
        tick();
        chk("glitch_idle", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        pwr_good = 1'b1;
        wait_release("glitch_requal", n);
        chk_val("glitch_release_edges", n, PWR);

        // Timeout / retry exhaustion: 20 high, 5 low, 20 high, 5 low, 20 high.
        do_reset(1'b0);
        pwr_good = 1'b1;
        wait_release("to_wait", n);
        chk_val("to_release_edges", n, PWR);
        for (int k = 0; k <= 70; k++) begin
            if (k > 0) tick();
            exp_p = (k < 20) || (k >= 25 && k < 45) || (k >= 50 && k < 70);
            chk_val($sformatf("to_perst_k%0d", k), int'(perst_n), int'(exp_p));
            chk_model("to_model");
        end
        chk("to_fail", 1'b0, 1'b0, 1'b1, 2'd2, 3'd5);
        tick();
        chk("to_fail_sticky", 1'b0, 1'b0, 1'b1, 2'd2, 3'd5);

        // Recovery from FAIL via software request.
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
        chk("rec_hold", 1'b0, 1'b0, 1'b0, 2'd0, 3'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rec_hold_n", 1'b0, 1'b0, 1'b0, 2'd0, 3'd4);
        end
        tick();
        chk("rec_release", 1'b1, 1'b0, 1'b0, 2'd0, 3'd2);
        link_up = 1'b1;
        tick();
        chk("rec_up", 1'b1, 1'b1, 1'b0, 2'd0, 3'd3);

        // Surprise link drop, then request racing power loss.
        link_up = 1'b0;
        tick();
        chk("drop_hold", 1'b0, 1'b0, 1'b0, 2'd0, 3'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_model("drop_hold_n");
        end
        tick();
        chk("drop_release", 1'b1, 1'b0, 1'b0, 2'd0, 3'd2);
        link_up = 1'b1;
        tick();
        chk("drop_up", 1'b1, 1'b1, 1'b0, 2'd0, 3'd3);
        reset_req = 1'b1;
        pwr_good  = 1'b0;
        tick();
        reset_req = 1'b0;
        chk("req_vs_pg", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

        // Asynchronous reset while UP.
        pwr_good = 1'b1;
        link_up  = 1'b0;
        wait_release("ar_wait", n);
        link_up = 1'b1;
        tick();
        chk("ar_up", 1'b1, 1'b1, 1'b0, 2'd0, 3'd3);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        m_reset();

        // Randomized run against the model.
        do_reset(1'b0);
        pwr_good = 1'b1;
        link_up  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            pwr_good  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 29) == 0) link_up = ~link_up;
            reset_req = ($urandom_range(0, 149) == 0);
            tick();
            chk_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcie_perst_gen.md
Name: pcie_perst_gen

Overview:
- Initiator side of the PERST#/power-good reset handshake.
- Drives a registered PERST# to a downstream PCIe device or slot, sequenced from a board power-good input.
- After releasing PERST#, monitors link-up with a timeout and re-pulses PERST# on failure, up to a retry limit.
- Sits in the board-level reset domain next to the endpoint-side reset logic; status outputs go to CSRs.

Parameters:
- PWR_STABLE_CYCLES, 10000000: consecutive clk cycles pwr_good must be high before PERST# release (100 ms at 100 MHz).
- PERST_MIN_CYCLES, 10000: minimum PERST# assertion width for a retry or requested reset (100 us).
- LINK_TIMEOUT_CYCLES, 100000000: cycles after release to wait for link_up (1 s).
- MAX_RETRIES, 3: re-pulses allowed before declaring failure; must be ≥ 0.

Ports:
- clk, input, 1: clock; all other inputs are synchronous to it.
- rst, input, 1: reset, asynchronous, active-low.
- pwr_good, input, 1: slot power stable.
- link_up, input, 1: link-trained indication from the LTSSM/data-link layer.
- reset_req, input, 1: single-cycle software request for a fresh PERST# pulse.
- perst_n, output, 1: PERST# to the device, active-low, registered.
- link_ok, output, 1: high while in state UP.
- link_fail, output, 1: high while in state FAIL (sticky until clear).
- retry_cnt, output, $clog2(MAX_RETRIES+1): number of retries used in the current attempt.
- state_o, output, 3: encoded state for CSR/debug.

Behaviour:
- All outputs are registered.
- Reset values (rst=0): perst_n=0, link_ok=0, link_fail=0, retry_cnt=0, state=IDLE, cycle counter=0.
- One shared cycle counter, width $clog2 of the largest count parameter + 1.
- State encodings: IDLE=0, PWR_WAIT=1, RELEASE=2, UP=3, HOLD=4, FAIL=5.
- IDLE: perst_n=0; cnt=0; retry_cnt=0.
  - pwr_good=1 → PWR_WAIT with cnt=1.
- PWR_WAIT: perst_n=0; each pwr_good=1 sample increments cnt.
  - The edge that takes the PWR_STABLE_CYCLES-th consecutive high sample moves to RELEASE and sets perst_n=1 at that same edge.
  - pwr_good=0 → IDLE.
- RELEASE: perst_n=1; cnt counts from 0.
  - link_up=1 → UP.
  - Otherwise, once cnt reaches LINK_TIMEOUT_CYCLES-1:
    - if retry_cnt<MAX_RETRIES: → HOLD, retry_cnt+1, perst_n=0 at that edge.
    - else: → FAIL.
  - link_up and timeout on the same cycle: link_up wins → UP.
- UP: perst_n=1, link_ok=1.
  - link_up=0 → HOLD with retry_cnt cleared to 0 (surprise link-down starts a fresh attempt).
- HOLD: perst_n=0 for exactly PERST_MIN_CYCLES cycles, then → RELEASE with perst_n=1.
- FAIL: perst_n=0, link_fail=1.
  - Exits only on reset_req (→ HOLD, retry_cnt=0) or pwr_good=0 (→ IDLE).
- Priority, highest first:
  1. pwr_good=0 in any state → IDLE next edge, perst_n=0.
  2. reset_req=1 in RELEASE, UP, HOLD or FAIL → HOLD, cnt=0, retry_cnt=0; this restarts the full HOLD width even mid-HOLD.
  3. Per-state transitions above.
- reset_req is ignored in IDLE and PWR_WAIT.
- perst_n must never be 1 outside RELEASE and UP, and never glitch.
- Async reset assertion forces perst_n=0 immediately, without waiting for a clk edge. Deassertion is expected synchronised upstream.
- retry_cnt saturates at MAX_RETRIES.

Test Plan:
Bench parameters: PWR_STABLE_CYCLES=10, PERST_MIN_CYCLES=5, LINK_TIMEOUT_CYCLES=20, MAX_RETRIES=2.
- Power-up: rst released, pwr_good=1 from edge 1 → perst_n rises after edge 10, state=RELEASE; link_up=1 at 3rd RELEASE cycle → link_ok=1, state=3.
- Power glitch: pwr_good drops at 7th PWR_WAIT sample → IDLE, perst_n stays 0; a later 10 consecutive highs are needed before release.
- Timeout/retry: link_up never asserted → perst_n pattern is 20 high, 5 low, 20 high, 5 low, 20 high; retry_cnt reaches 2; then FAIL, link_fail=1, perst_n=0.
- Recovery: in FAIL pulse reset_req → HOLD for 5 cycles, retry_cnt=0, perst_n=1, link_up=1 → UP, link_fail=0.
- Link drop: in UP, link_up→0 → perst_n low 5 cycles, retry_cnt=0; simultaneous reset_req and pwr_good=0 → IDLE wins.
- Mid-operation reset: rst asserted in UP → perst_n=0 asynchronously, all outputs at reset values.
